bus_arbiter: RTL and testbench

Shared-memory bus arbiter between four cores and the unified memory system. It has two independent channels, data (D) and instruction (I). Each channel grants its memory port to exactly one requesting core and routes that core's address, data and strobes to the memory-side bus. A grant is held until the core withdraws its request.

---
 rtl/bus_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Four-core shared-memory arbiter with independent data (D) and instruction (I) channels.
// Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin winner selection; otherwise fixed priority (lowest index).

module bus_arbiter_channel #(
  parameter int N_CORES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_CORES-1:0] busRq,
  input  logic               memReady,
  output logic [N_CORES-1:0] busGrant
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic [N_CORES-1:0] grantReg;
  logic [N_CORES-1:0] grantNext;
  logic [N_CORES-1:0] winner;
  logic               arbitrate;

  function automatic logic [IDX_W-1:0] toIdx(input logic [N_CORES-1:0] oneHot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < N_CORES; k++) begin
      if (oneHot[IDX_W'(k)]) begin
        idx = IDX_W'(k);
      end
    end
    return idx;
  endfunction

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] lastIdx;
  logic [IDX_W-1:0] lastIdxNext;

  // Search begins just after the previous owner, so that owner ends up with lowest priority.
  function automatic logic [N_CORES-1:0] pickWinner(input logic [N_CORES-1:0] rq,
                                                    input logic [IDX_W-1:0]   last);
    logic [N_CORES-1:0] win;
    logic [IDX_W-1:0]   idx;
    logic               found;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_CORES; k++) begin
      idx = IDX_W'((int'(last) + k) % N_CORES);
      if (!found && rq[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return win;
  endfunction

  assign winner = pickWinner(busRq, lastIdx);
`else
  function automatic logic [N_CORES-1:0] pickWinner(input logic [N_CORES-1:0] rq);
    logic [N_CORES-1:0] win;
    logic               found;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_CORES; k++) begin
      if (!found && rq[IDX_W'(k)]) begin
        win[IDX_W'(k)] = 1'b1;
        found          = 1'b1;
      end
    end
    return win;
  endfunction

  assign winner = pickWinner(busRq);
`endif

  // A new grant needs a pending request and a quiet memory port.
  assign arbitrate = (|busRq) && !memReady;

  // State, grant and owner-pointer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grantReg <= '0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      lastIdx  <= IDX_W'(N_CORES - 1);
`endif
    end else begin
      state    <= stateNext;
      grantReg <= grantNext;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      lastIdx  <= lastIdxNext;
`endif
    end
  end

  // Next-state logic; RELEASE may hand over directly so owners are separated by exactly one dead cycle.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE, RELEASE: begin
        if (arbitrate) begin
          stateNext = BUSY;
        end else begin
          stateNext = IDLE;
        end
      end
      BUSY: begin
        if ((busRq & grantReg) == '0) begin
          stateNext = RELEASE;
        end else begin
          stateNext = BUSY;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Grant value to register at the next edge; the owner is never preempted.
  always_comb begin
    grantNext = '0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    lastIdxNext = lastIdx;
`endif
    case (state)
      IDLE, RELEASE: begin
        if (arbitrate) begin
          grantNext = winner;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
          lastIdxNext = toIdx(winner);
`endif
        end else begin
          grantNext = '0;
        end
      end
      BUSY: begin
        if ((busRq & grantReg) != '0) begin
          grantNext = grantReg;
        end else begin
          grantNext = '0;
        end
      end
      default: grantNext = '0;
    endcase
  end

  assign busGrant = grantReg;

endmodule

module bus_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_CORES-1:0]            D_Bus_RQ,
  input  logic [N_CORES-1:0]            I_Bus_RQ,
  output logic [N_CORES-1:0]            D_Bus_GRANT,
  output logic [N_CORES-1:0]            I_Bus_GRANT,
  input  logic [N_CORES-1:0]            D_Core_Read,
  input  logic [(DATA_W/8)*N_CORES-1:0] D_Core_Write,
  input  logic [ADDR_W*N_CORES-1:0]     D_Core_Address,
  input  logic [DATA_W*N_CORES-1:0]     D_Core_WData,
  input  logic [ADDR_W*N_CORES-1:0]     I_Core_Address,
  input  logic                          DataMem_Ready,
  output logic                          DataMem_Read,
  output logic [DATA_W/8-1:0]           DataMem_Write,
  output logic [ADDR_W-1:0]             DataMem_Address,
  output logic [DATA_W-1:0]             DataMem_Out,
  input  logic                          InstMem_Ready,
  output logic [ADDR_W-1:0]             InstMem_Address,
  output logic                          InstMem_Read
);

  localparam int BE_W = DATA_W / 8;
  localparam int D_W  = 1 + BE_W + ADDR_W + DATA_W;

  logic [N_CORES-1:0]       dGrant;
  logic [N_CORES-1:0]       iGrant;
  logic [D_W*N_CORES-1:0]   dMasked;
  logic [ADDR_W*N_CORES-1:0] iMasked;
  logic [D_W-1:0]           dBus;
  logic [ADDR_W-1:0]        iBus;

  bus_arbiter_channel #(.N_CORES(N_CORES)) dChannel (
    .clock    (clock),
    .reset    (reset),
    .busRq    (D_Bus_RQ),
    .memReady (DataMem_Ready),
    .busGrant (dGrant)
  );

  bus_arbiter_channel #(.N_CORES(N_CORES)) iChannel (
    .clock    (clock),
    .reset    (reset),
    .busRq    (I_Bus_RQ),
    .memReady (InstMem_Ready),
    .busGrant (iGrant)
  );

  // Each core's fields are gated by its own grant bit, so nothing reaches the bus without a grant.
  for (genvar g = 0; g < N_CORES; g++) begin : gMask
    assign dMasked[g*D_W +: D_W] = {D_Core_Read[g],
                                    D_Core_Write[g*BE_W +: BE_W],
                                    D_Core_Address[g*ADDR_W +: ADDR_W],
                                    D_Core_WData[g*DATA_W +: DATA_W]} & {D_W{dGrant[g]}};
    assign iMasked[g*ADDR_W +: ADDR_W] = I_Core_Address[g*ADDR_W +: ADDR_W] & {ADDR_W{iGrant[g]}};
  end

  // OR-combine the gated fields; the grants are one-hot or zero.
  always_comb begin
    dBus = '0;
    iBus = '0;
    for (int i = 0; i < N_CORES; i++) begin
      dBus = dBus | dMasked[i*D_W +: D_W];
      iBus = iBus | iMasked[i*ADDR_W +: ADDR_W];
    end
  end

  assign {DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out} = dBus;
  assign InstMem_Address = iBus;
  assign InstMem_Read    = |iGrant;
  assign D_Bus_GRANT     = dGrant;
  assign I_Bus_GRANT     = iGrant;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (both selection builds).

module tb_bus_arbiter;

  logic         clock;
  logic         reset;
  logic [3:0]   D_Bus_RQ;
  logic [3:0]   I_Bus_RQ;
  logic [3:0]   D_Bus_GRANT;
  logic [3:0]   I_Bus_GRANT;
  logic [3:0]   D_Core_Read;
  logic [15:0]  D_Core_Write;
  logic [119:0] D_Core_Address;
  logic [127:0] D_Core_WData;
  logic [119:0] I_Core_Address;
  logic         DataMem_Ready;
  logic         DataMem_Read;
  logic [3:0]   DataMem_Write;
  logic [29:0]  DataMem_Address;
  logic [31:0]  DataMem_Out;
  logic         InstMem_Ready;
  logic [29:0]  InstMem_Address;
  logic         InstMem_Read;

  int checks = 0;
  int errors = 0;
  logic [3:0] order [5];

  bus_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .D_Bus_RQ        (D_Bus_RQ),
    .I_Bus_RQ        (I_Bus_RQ),
    .D_Bus_GRANT     (D_Bus_GRANT),
    .I_Bus_GRANT     (I_Bus_GRANT),
    .D_Core_Read     (D_Core_Read),
    .D_Core_Write    (D_Core_Write),
    .D_Core_Address  (D_Core_Address),
    .D_Core_WData    (D_Core_WData),
    .I_Core_Address  (I_Core_Address),
    .DataMem_Ready   (DataMem_Ready),
    .DataMem_Read    (DataMem_Read),
    .DataMem_Write   (DataMem_Write),
    .DataMem_Address (DataMem_Address),
    .DataMem_Out     (DataMem_Out),
    .InstMem_Ready   (InstMem_Ready),
    .InstMem_Address (InstMem_Address),
    .InstMem_Read    (InstMem_Read)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    reset          = 1'b0;
    D_Bus_RQ       = 4'b1111;
    I_Bus_RQ       = 4'b0000;
    D_Core_Read    = 4'b0101;
    D_Core_Write   = 16'h8421;
    D_Core_Address = {30'h00F9, 30'h03C7, 30'h02A5, 30'h0123};
    D_Core_WData   = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    I_Core_Address = {30'h3333, 30'h2222, 30'h1111, 30'h0444};
    DataMem_Ready  = 1'b0;
    InstMem_Ready  = 1'b0;

    // Reset held with all requests up
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rst_dgrant", D_Bus_GRANT, 4'b0000);
      check("rst_daddr", DataMem_Address, 30'h0);
    end
    check("rst_iread", InstMem_Read, 1'b0);
    reset = 1'b1;
    tick();
    check("first_grant", D_Bus_GRANT, 4'b0001);
    check("first_addr", DataMem_Address, 30'h123);
    check("first_read", DataMem_Read, 1'b1);
    check("first_write", DataMem_Write, 4'h1);
    check("first_wdata", DataMem_Out, 32'hA000_0000);
    D_Bus_RQ = 4'b0000;
    tick();
    check("drop_grant", D_Bus_GRANT, 4'b0000);
    check("drop_addr", DataMem_Address, 30'h0);
    tick();

    // Single owner, Ready pulse and a competing request do not revoke
    D_Bus_RQ = 4'b0001;
    tick();
    check("own_grant", D_Bus_GRANT, 4'b0001);
    DataMem_Ready = 1'b1;
    D_Bus_RQ      = 4'b0011;
    tick();
    check("hold_grant", D_Bus_GRANT, 4'b0001);
    check("hold_addr", DataMem_Address, 30'h123);
    DataMem_Ready = 1'b0;
    D_Bus_RQ      = 4'b0001;
    tick();
    check("hold2_grant", D_Bus_GRANT, 4'b0001);
    D_Bus_RQ = 4'b0000;
    tick();
    check("rel_grant", D_Bus_GRANT, 4'b0000);
    check("rel_read", DataMem_Read, 1'b0);
    tick();

    // Handover 0 -> 1 with exactly one dead cycle
    D_Bus_RQ = 4'b0001;
    tick();
    check("ho_g0", D_Bus_GRANT, 4'b0001);
    D_Bus_RQ = 4'b0010;
    tick();
    check("ho_dead", D_Bus_GRANT, 4'b0000);
    check("ho_dead_addr", DataMem_Address, 30'h0);
    tick();
    check("ho_g1", D_Bus_GRANT, 4'b0010);
    check("ho_addr1", DataMem_Address, 30'h2A5);
    check("ho_write1", DataMem_Write, 4'h2);
    check("ho_read1", DataMem_Read, 1'b0);
    D_Bus_RQ = 4'b0000;
    tick();
    tick();

    // Asynchronous reset in the middle of a grant
    D_Bus_RQ = 4'b1111;
    tick();
    check("pre_rst_any", |D_Bus_GRANT, 1'b1);
    reset = 1'b0;
    #1;
    check("async_grant", D_Bus_GRANT, 4'b0000);
    check("async_addr", DataMem_Address, 30'h0);
    tick();
    reset = 1'b1;

    // Rotation with all requests held, each owner dropping for one cycle
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("order%0d", k), D_Bus_GRANT, order[k]);
      D_Bus_RQ = 4'b1111 & ~order[k];
      tick();
      check($sformatf("order_gap%0d", k), D_Bus_GRANT, 4'b0000);
      D_Bus_RQ = 4'b1111;
    end
    tick();
    D_Bus_RQ = 4'b0000;
    tick();
    tick();

    // Ready high at release blocks the pending request
    D_Bus_RQ = 4'b0001;
    tick();
    check("rdy_g0", D_Bus_GRANT, 4'b0001);
    D_Bus_RQ      = 4'b0010;
    DataMem_Ready = 1'b1;
    tick();
    check("rdy_rel", D_Bus_GRANT, 4'b0000);
    tick();
    check("rdy_block1", D_Bus_GRANT, 4'b0000);
    tick();
    check("rdy_block2", D_Bus_GRANT, 4'b0000);
    DataMem_Ready = 1'b0;
    tick();
    check("rdy_g1", D_Bus_GRANT, 4'b0010);
    D_Bus_RQ = 4'b0000;
    tick();
    tick();

    // Both channels granted in the same cycle to different cores
    check("i_idle_read", InstMem_Read, 1'b0);
    check("i_idle_addr", InstMem_Address, 30'h0);
    I_Bus_RQ = 4'b0100;
    D_Bus_RQ = 4'b0001;
    tick();
    check("conc_dgrant", D_Bus_GRANT, 4'b0001);
    check("conc_igrant", I_Bus_GRANT, 4'b0100);
    check("conc_iread", InstMem_Read, 1'b1);
    check("conc_iaddr", InstMem_Address, 30'h2222);
    check("conc_daddr", DataMem_Address, 30'h123);
    I_Bus_RQ = 4'b0000;
    tick();
    check("i_rel_grant", I_Bus_GRANT, 4'b0000);
    check("i_rel_read", InstMem_Read, 1'b0);
    check("d_still", D_Bus_GRANT, 4'b0001);
    D_Bus_RQ = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
